joy_db15_np: RTL and testbench
==============================

// Module: joy_db15_np
// PURPOSE
// Parametrised serial reader for the DB15 joystick splitter: drives JOY_CLK/JOY_LOAD, shifts in
// NUM_PLAYERS*BITS_PER_PLAYER bits per frame and presents active-high, debounced button words.
// Generalises the fixed 2-player/24-bit reader to 1-4 players, with a programmable clock divider,
// frame-consistency debounce, frame strobe and change strobe. Sits between the cart core's I/O pins and the input mux.
// PARAMETERS
// NUM_PLAYERS      2    players on the chain, 1..4
// BITS_PER_PLAYER  12   bits per player in the serial stream, 1..16
// HALF_PERIOD      256  clk cycles per JOY_CLK half-period, >=4
// DEBOUNCE         1    identical consecutive frames required before outputs update, 1..15 (1 = no filtering)
// PORTS
// clk          in   1        system clock, 48-50 MHz
// reset        in   1        synchronous, active-high
// JOY_CLK      out  1        splitter shift clock, registered, generated from clk
// JOY_LOAD     out  1        splitter parallel-load, active-low
// JOY_DATA     in   1        serial data from splitter, asynchronous, active-low buttons
// joy_out      out  16*NUM_PLAYERS  player p at [16p+15:16p]; stream bit k of player p -> bit k; unused upper bits 0
// frame_stb    out  1        1-clk pulse per completed frame
// change_stb   out  1        1-clk pulse when joy_out changes value
// valid        out  1        high after the first debounced commit since reset
// BEHAVIOUR
// - Only clk is used as a clock; JOY_CLK is a data output, never a clock inside the block.
// - Divider: counter 0..HALF_PERIOD-1; at terminal count emit tick, toggle JOY_CLK. rise = tick while JOY_CLK==0.
// - JOY_DATA passes through a 2-FF synchroniser; samples use the synchronised value at rise.
// - N = NUM_PLAYERS*BITS_PER_PLAYER. Frame = N+2 JOY_CLK periods, rise index r = 0..N+1:
//   LOAD  (r=0): JOY_LOAD=0 for this whole JOY_CLK period (from this rise until the next rise).
//   SETTLE(r=1): JOY_LOAD=1, no sample taken.
//   SHIFT (r=2..N+1): sample bit k=r-2 into shift[k], inverted (JOY_DATA low -> 1).
//   COMMIT: one clk after the rise for r=N+1; frame_stb=1; next rise restarts at LOAD.
// - Stream order: player 0 bits 0..BITS_PER_PLAYER-1, then player 1, and so on. No button remap in this block.
// - Debounce at COMMIT: if shift==cand then stable_cnt++ (saturating at DEBOUNCE), else cand<=shift and stable_cnt<=1.
//   When stable_cnt reaches DEBOUNCE and cand!=joy_out: joy_out<=cand and change_stb=1 on the same clk as frame_stb.
//   valid sets on the first commit where stable_cnt>=DEBOUNCE and stays high until reset.
// - Output latency: joy_out updates 1 clk after the final sample rise of the DEBOUNCE-th matching frame.
// - Reset (any cycle, including mid-frame): JOY_CLK=0, JOY_LOAD=1, divider=0, state=LOAD pending at the first rise.
//   Also clears shift, cand, stable_cnt, joy_out=0, frame_stb=0, change_stb=0, valid=0. Partial frames are discarded.
// - All outputs are registered; strobes never exceed 1 clk; frame_stb and change_stb fire only in COMMIT.
// - Defaults (2 players, 12 bits, HALF_PERIOD=256) give a 26-period frame of 512-clk JOY_CLK periods.
// TESTING
// T1 reset: hold reset 5 clks -> JOY_CLK=0, JOY_LOAD=1, joy_out=0, valid=0; first JOY_CLK rise after 256 clks.
// T2 timing: defaults -> JOY_LOAD low for exactly 512 clks, frame_stb period = 26*512 = 13312 clks.
// T3 data: model drives all bits high except stream bit 4 (P0 bit4) and bit 17 (P1 bit5) low
//    -> joy_out[4]=1, joy_out[21]=1, all other bits 0; change_stb and valid pulse with the 1st frame_stb.
// T4 debounce: DEBOUNCE=3; pattern A for 2 frames, glitch B for 1 frame, A for 3 frames
//    -> joy_out stays 0 until the 3rd consecutive A frame, then equals A; B never appears.
// T5 reset mid-frame: assert reset at r=10 -> next frame restarts at LOAD; no frame_stb from the partial frame.
// T6 params: NUM_PLAYERS=4, BITS_PER_PLAYER=16, HALF_PERIOD=4 -> 66-period frame; bit 63 low -> joy_out[63]=1.

Source files
------------

// File: rtl/joy_db15_np.sv
// DB15 splitter serial reader: generates JOY_CLK/JOY_LOAD, shifts in
// N players of button bits, debounces whole frames and presents active-high words.
module joy_db15_np #(
    parameter int NUM_PLAYERS     = 2,
    parameter int BITS_PER_PLAYER = 12,
    parameter int HALF_PERIOD     = 256,
    parameter int DEBOUNCE        = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      JOY_CLK,
    output logic                      JOY_LOAD,
    input  logic                      JOY_DATA,
    output logic [16*NUM_PLAYERS-1:0] joy_out,
    output logic                      frame_stb,
    output logic                      change_stb,
    output logic                      valid
);

    localparam int N  = NUM_PLAYERS * BITS_PER_PLAYER;
    localparam int OW = 16 * NUM_PLAYERS;
    localparam int RW = $clog2(N + 2);
    localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);
    localparam logic [RW-1:0] R_LAST   = RW'(N + 1);
    localparam logic [3:0]    DEB      = 4'(DEBOUNCE);

    logic [DW-1:0] div_q;
    logic          jclk_q;
    logic          jload_q;
    logic [1:0]    sync_q;
    logic [RW-1:0] r_q;
    logic          commit_q;
    logic [N-1:0]  shift_q;
    logic [N-1:0]  shift_d;
    logic [N-1:0]  cand_q;
    logic [N-1:0]  cand_d;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic [OW-1:0] joy_q;
    logic [OW-1:0] joy_d;
    logic          fstb_q;
    logic          cstb_q;
    logic          valid_q;

    logic tick;
    logic rise;
    logic same;
    logic stable;

    assign tick = (div_q == DIV_LAST);
    assign rise = tick & ~jclk_q;

    always_comb begin
        shift_d = shift_q;
        if (rise) begin
            for (int k = 0; k < N; k++) begin
                if (r_q == RW'(k + 2)) shift_d[k] = ~sync_q[1];
            end
        end
    end

    // A frame counts toward stability only if it matches the current candidate.
    always_comb begin
        same   = (shift_q == cand_q);
        cand_d = same ? cand_q : shift_q;
        if (!same)
            cnt_d = 4'd1;
        else if (cnt_q >= DEB)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 4'd1;
        stable = (cnt_d >= DEB);
        joy_d  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int k = 0; k < BITS_PER_PLAYER; k++) begin
                joy_d[16*p+k] = cand_d[p*BITS_PER_PLAYER+k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            jclk_q   <= 1'b0;
            jload_q  <= 1'b1;
            sync_q   <= 2'b11;
            r_q      <= '0;
            commit_q <= 1'b0;
            shift_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            joy_q    <= '0;
            fstb_q   <= 1'b0;
            cstb_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], JOY_DATA};
            div_q    <= tick ? '0 : div_q + 1'b1;
            fstb_q   <= 1'b0;
            cstb_q   <= 1'b0;
            commit_q <= 1'b0;
            shift_q  <= shift_d;
            if (tick) jclk_q <= ~jclk_q;
            if (rise) begin
                if (r_q == '0)         jload_q <= 1'b0;
                if (r_q == RW'(1))     jload_q <= 1'b1;
                r_q      <= (r_q == R_LAST) ? '0 : r_q + 1'b1;
                commit_q <= (r_q == R_LAST);
            end
            if (commit_q) begin
                cand_q <= cand_d;
                cnt_q  <= cnt_d;
                fstb_q <= 1'b1;
                if (stable) begin
                    valid_q <= 1'b1;
                    if (joy_d != joy_q) begin
                        joy_q  <= joy_d;
                        cstb_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign JOY_CLK    = jclk_q;
    assign JOY_LOAD   = jload_q;
    assign joy_out    = joy_q;
    assign frame_stb  = fstb_q;
    assign change_stb = cstb_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_joy_db15_np.sv
// Bench for joy_db15_np: three instances (defaults, debounce=3, 4x16 fast)
// each fed by a behavioural splitter; frames checked against tables and a history model.
module tb_joy_db15_np;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, rst2;
    logic        jclk0, jclk1, jclk2;
    logic        jload0, jload1, jload2;
    logic        d0 = 1'b1, d1 = 1'b1, d2 = 1'b1;
    logic [31:0] jo0, jo1;
    logic [63:0] jo2;
    logic        fs0, fs1, fs2, cs0, cs1, cs2, v0, v1, v2;
    logic [63:0] btn0, btn1, btn2;
    logic [63:0] img0, img1, img2;
    int          idx0, idx1, idx2;

    joy_db15_np u0 (
        .clk(clk), .reset(rst0), .JOY_CLK(jclk0), .JOY_LOAD(jload0),
        .JOY_DATA(d0), .joy_out(jo0), .frame_stb(fs0),
        .change_stb(cs0), .valid(v0));

    joy_db15_np #(.NUM_PLAYERS(2), .BITS_PER_PLAYER(12),
                  .HALF_PERIOD(4), .DEBOUNCE(3)) u1 (
        .clk(clk), .reset(rst1), .JOY_CLK(jclk1), .JOY_LOAD(jload1),
        .JOY_DATA(d1), .joy_out(jo1), .frame_stb(fs1),
        .change_stb(cs1), .valid(v1));

    joy_db15_np #(.NUM_PLAYERS(4), .BITS_PER_PLAYER(16),
                  .HALF_PERIOD(4), .DEBOUNCE(1)) u2 (
        .clk(clk), .reset(rst2), .JOY_CLK(jclk2), .JOY_LOAD(jload2),
        .JOY_DATA(d2), .joy_out(jo2), .frame_stb(fs2),
        .change_stb(cs2), .valid(v2));

    // Splitter model: latch buttons while LOAD is low, then present
    // stream bit k (active-low) on the JOY_CLK fall before its sampling rise.
    initial forever begin
        @(negedge jclk0); #1;
        if (!jload0) begin img0 = btn0; idx0 = 0; end
        else begin d0 = ~img0[idx0]; if (idx0 < 63) idx0++; end
    end
    initial forever begin
        @(negedge jclk1); #1;
        if (!jload1) begin img1 = btn1; idx1 = 0; end
        else begin d1 = ~img1[idx1]; if (idx1 < 63) idx1++; end
    end
    initial forever begin
        @(negedge jclk2); #1;
        if (!jload2) begin img2 = btn2; idx2 = 0; end
        else begin d2 = ~img2[idx2]; if (idx2 < 63) idx2++; end
    end

    typedef struct {
        logic [63:0] btn;
        logic [63:0] exp;
        logic        chg;
        logic        vld;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic stb(input int w);
        return (w == 0) ? fs0 : ((w == 1) ? fs1 : fs2);
    endfunction

    task automatic wait_stb(input int w, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!stb(w) && n < limit);
        if (!stb(w)) begin
            tests++;
            fails++;
            $display("FAIL timeout_stb%0d: got none within %0d clks", w, limit);
        end
    endtask

    // Stream bit p*12+k appears at joy_out[16p+k].
    function automatic logic [63:0] pack12(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 12; k++)
                r[16*p+k] = w[12*p+k];
        return r;
    endfunction

    vec_t        tab1[6];
    vec_t        tab2[6];
    logic [63:0] hist[$];
    logic [63:0] expv, w, prev;
    logic        chg, pj;
    int          n, m, r, seen;

    localparam logic [63:0] A  = 64'h0000_0000_005A_3C81;
    localparam logic [63:0] B  = 64'h0000_0000_0000_0123;
    localparam logic [63:0] C  = 64'h0000_0000_00AB_C123;
    localparam logic [63:0] HI = 64'h8000_0000_0000_0000;

    initial begin
        tab1[0] = '{A, 64'h0, 1'b0, 1'b0};
        tab1[1] = '{A, 64'h0, 1'b0, 1'b0};
        tab1[2] = '{B, 64'h0, 1'b0, 1'b0};
        tab1[3] = '{A, 64'h0, 1'b0, 1'b0};
        tab1[4] = '{A, 64'h0, 1'b0, 1'b0};
        tab1[5] = '{A, 64'h0000_0000_05A3_0C81, 1'b1, 1'b1};
        tab2[0] = '{HI, HI, 1'b1, 1'b1};
        tab2[1] = '{HI, HI, 1'b0, 1'b1};
        tab2[2] = '{64'h1, 64'h1, 1'b1, 1'b1};
        tab2[3] = '{'1, '1, 1'b1, 1'b1};
        tab2[4] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1};
        tab2[5] = '{64'h0, 64'h0, 1'b1, 1'b1};

        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        btn0 = 64'h0000_0000_0002_0010;
        btn1 = '0;
        btn2 = '0;
        repeat (5) @(negedge clk);

        chk("rst_jclk", {63'b0, jclk0}, 64'd0);
        chk("rst_jload", {63'b0, jload0}, 64'd1);
        chk("rst_joy", {32'b0, jo0}, 64'd0);
        chk("rst_valid", {63'b0, v0}, 64'd0);

        rst0 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!jclk0 && n < 1000);
        chk("first_rise", 64'(n), 64'd256);
        chk("load_at_r0", {63'b0, jload0}, 64'd0);
        n = 0;
        while (!jload0 && n < 2000) begin n++; @(negedge clk); end
        chk("load_len", 64'(n), 64'd512);

        wait_stb(0, 20000, n);
        chk("t3_joy", {32'b0, jo0}, 64'h0000_0000_0020_0010);
        chk("t3_change", {63'b0, cs0}, 64'd1);
        chk("t3_valid", {63'b0, v0}, 64'd1);
        wait_stb(0, 20000, n);
        chk("frame_period", 64'(n), 64'd13312);
        chk("t3_nochange", {63'b0, cs0}, 64'd0);
        chk("t3_hold", {32'b0, jo0}, 64'h0000_0000_0020_0010);

        rst2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn2 = tab2[i].btn;
            wait_stb(2, 2000, n);
            if (i == 1) chk("t6_period", 64'(n), 64'd528);
            chk($sformatf("t6_joy%0d", i), jo2, tab2[i].exp);
            chk($sformatf("t6_chg%0d", i), {63'b0, cs2}, {63'b0, tab2[i].chg});
            chk($sformatf("t6_vld%0d", i), {63'b0, v2}, {63'b0, tab2[i].vld});
        end

        rst1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn1 = tab1[i].btn;
            wait_stb(1, 1000, n);
            chk($sformatf("t4_joy%0d", i), {32'b0, jo1}, tab1[i].exp);
            chk($sformatf("t4_chg%0d", i), {63'b0, cs1}, {63'b0, tab1[i].chg});
            chk($sformatf("t4_vld%0d", i), {63'b0, v1}, {63'b0, tab1[i].vld});
        end

        hist = {A, A, A};
        expv = pack12(A);
        prev = A;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 9) < 7) w = prev;
            else w = 64'($urandom) & 64'hFF_FFFF;
            prev = w;
            btn1 = w;
            wait_stb(1, 1000, n);
            hist.push_back(w);
            if (hist.size() > 3) void'(hist.pop_front());
            chg = 1'b0;
            if (hist[0] == hist[1] && hist[1] == hist[2]) begin
                chg  = (pack12(w) != expv);
                expv = pack12(w);
            end
            chk($sformatf("rnd_joy%0d", i), {32'b0, jo1}, expv);
            chk($sformatf("rnd_chg%0d", i), {63'b0, cs1}, {63'b0, chg});
        end

        n = 0;
        do begin @(negedge clk); n++; end while (jload1 && n < 500);
        r = 0; seen = 0; pj = jclk1; n = 0;
        while (r < 10 && n < 500) begin
            @(negedge clk);
            n++;
            if (jclk1 && !pj) r++;
            pj = jclk1;
            if (fs1) seen++;
        end
        chk("t5_reach_r10", 64'(r), 64'd10);
        rst1 = 1'b1;
        btn1 = C;
        repeat (2) begin @(negedge clk); if (fs1) seen++; end
        chk("t5_joy_rst", {32'b0, jo1}, 64'd0);
        chk("t5_valid_rst", {63'b0, v1}, 64'd0);
        chk("t5_jclk_rst", {63'b0, jclk1}, 64'd0);
        chk("t5_jload_rst", {63'b0, jload1}, 64'd1);
        rst1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (fs1) seen++;
        end while (!jclk1 && n < 100);
        chk("t5_no_partial_stb", 64'(seen), 64'd0);
        chk("t5_first_rise", 64'(n), 64'd4);
        chk("t5_restart_load", {63'b0, jload1}, 64'd0);
        wait_stb(1, 1000, m);
        chk("t5_restart_len", 64'(n + m), 64'd205);
        chk("t5_f1_joy", {32'b0, jo1}, 64'd0);
        chk("t5_f1_vld", {63'b0, v1}, 64'd0);
        wait_stb(1, 1000, m);
        chk("t5_f2_joy", {32'b0, jo1}, 64'd0);
        wait_stb(1, 1000, m);
        chk("t5_f3_joy", {32'b0, jo1}, pack12(C));
        chk("t5_f3_chg", {63'b0, cs1}, 64'd1);
        chk("t5_f3_vld", {63'b0, v1}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
